gpr_wb_arbiter: RTL and testbench

Write-back arbiter and sequencer for the 2R1W 32x64 general-purpose register file. Up to three execution units (ALU, LSU, MUL/DIV) compete for the single GPR write port; the block grants one per cycle round-robin, registers the winning address and data onto the port, suppresses writes to x0, and optionally sweeps x1..x31 to zero after reset. It sits between the execute/memory stages and the GPR write port.

---
 rtl/gpr_wb_arbiter.sv | 112 +++++++++++
 tb/tb_gpr_wb_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: round-robin write-back arbiter for the single GPR write port.
// Grants one of NUM_REQ execution units per cycle, registers the winner onto the
// port and suppresses x0 writes. Define GPR_CLEAR_ON_RESET_EN to build the
// post-reset sweep that writes zero to x1..x31 before any grant is issued.
module gpr_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           hold,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           gpr_wen,
  output logic [ADDR_WIDTH-1:0]          gpr_waddr,
  output logic [DATA_WIDTH-1:0]          gpr_wdata,
  output logic                           clr_busy
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [LW-1:0] LAST_RST = LW'(NUM_REQ - 1);

  logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_a[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [LW-1:0] last;
  logic [LW-1:0] gidx;
  logic [LW:0]   sum;
  logic [LW-1:0] idx;
  logic          found;
  logic          run;

`ifdef GPR_CLEAR_ON_RESET_EN
  typedef enum logic {CLEAR, RUN} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt;

  assign run      = (state_q == RUN);
  assign clr_busy = (state_q == CLEAR);

  // Sweep ends once the top address has been issued.
  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && cnt == '1) state_d = RUN;
  end

  // State register; reset always restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) state_q <= CLEAR;
    else     state_q <= state_d;
  end
`else
  assign run      = 1'b1;
  assign clr_busy = 1'b0;
`endif

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    req_ready = '0;
    gidx      = last;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    if (run && !hold) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        sum = {1'b0, last} + (LW+1)'(k);
        if (sum >= (LW+1)'(NUM_REQ)) sum = sum - (LW+1)'(NUM_REQ);
        idx = sum[LW-1:0];
        if (!found && req_valid[idx]) begin
          found          = 1'b1;
          req_ready[idx] = 1'b1;
          gidx           = idx;
        end
      end
    end
  end

  // Write port registers, sweep counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
      last      <= LAST_RST;
`ifdef GPR_CLEAR_ON_RESET_EN
      cnt       <= ADDR_WIDTH'(1);
    end else if (state_q == CLEAR) begin
      gpr_wen   <= 1'b1;
      gpr_waddr <= cnt;
      gpr_wdata <= '0;
      cnt       <= cnt + 1'b1;
`endif
    end else if (found) begin
      // x0 writes are consumed but never reach the register file.
      gpr_wen   <= (addr_a[gidx] != '0);
      gpr_waddr <= addr_a[gidx];
      gpr_wdata <= data_a[gidx];
      last      <= gidx;
    end else begin
      gpr_wen   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter; follows GPR_CLEAR_ON_RESET_EN if defined.
module tb_gpr_wb_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         hold = 1'b0;
  logic [2:0]   req_valid = '0;
  logic [14:0]  req_addr = '0;
  logic [191:0] req_data = '0;
  logic [2:0]   req_ready;
  logic         gpr_wen;
  logic [4:0]   gpr_waddr;
  logic [63:0]  gpr_wdata;
  logic         clr_busy;

  int errors = 0;
  int checks = 0;

  gpr_wb_arbiter dut (
    .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef GPR_CLEAR_ON_RESET_EN
    repeat (31) tick();
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (gpr_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", gpr_wen); end
    checks++; if (gpr_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", gpr_waddr); end
    checks++; if (gpr_wdata !== 64'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", gpr_wdata); end
`ifdef GPR_CLEAR_ON_RESET_EN
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL reset_clr_busy got=%b exp=1", clr_busy); end
`else
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy got=%b exp=0", clr_busy); end
`endif
  endtask

`ifdef GPR_CLEAR_ON_RESET_EN
  task automatic test_clear;
    req_valid = 3'b111;
    req_addr  = {5'd7, 5'd6, 5'd5};
    req_data  = {64'hC, 64'hB, 64'hA};
    rst = 1'b0;
    #1;
    for (int c = 1; c <= 31; c++) begin
      checks++; if (req_ready !== 3'b000 || clr_busy !== 1'b1) begin errors++;
        $display("FAIL clear_busy c=%0d got ready=%b busy=%b exp ready=000 busy=1", c, req_ready, clr_busy); end
      tick();
      checks++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'(c) || gpr_wdata !== 64'd0) begin errors++;
        $display("FAIL clear_write c=%0d got wen=%b addr=%0d data=%h exp wen=1 addr=%0d data=0", c, gpr_wen, gpr_waddr, gpr_wdata, c); end
    end
    checks++; if (clr_busy !== 1'b0 || req_ready !== 3'b001) begin errors++;
      $display("FAIL clear_done got busy=%b ready=%b exp busy=0 ready=001", clr_busy, req_ready); end
    req_valid = '0;
  endtask
`else
  task automatic test_first_grant;
    rst = 1'b0;
    req_valid = 3'b010;
    req_addr  = {5'd0, 5'd31, 5'd0};
    req_data  = {64'h0, 64'h1234, 64'h0};
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL first_grant_ready got=%b exp=010", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd31 || gpr_wdata !== 64'h1234) begin errors++;
      $display("FAIL first_grant_write got wen=%b addr=%0d data=%h exp wen=1 addr=31 data=1234", gpr_wen, gpr_waddr, gpr_wdata); end
  endtask
`endif

  task automatic test_round_robin;
    logic [2:0] exp_rdy [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [4:0] exp_a   [6] = '{5'd5, 5'd6, 5'd7, 5'd5, 5'd6, 5'd7};
    logic [63:0] exp_d  [6] = '{64'hA, 64'hB, 64'hC, 64'hA, 64'hB, 64'hC};
    do_reset();
    req_valid = 3'b111;
    req_addr  = {5'd7, 5'd6, 5'd5};
    req_data  = {64'hC, 64'hB, 64'hA};
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (req_ready !== exp_rdy[i]) begin errors++; $display("FAIL rr_ready i=%0d got=%b exp=%b", i, req_ready, exp_rdy[i]); end
      tick();
      checks++; if (gpr_wen !== 1'b1 || gpr_waddr !== exp_a[i] || gpr_wdata !== exp_d[i]) begin errors++;
        $display("FAIL rr_write i=%0d got wen=%b addr=%0d data=%h exp wen=1 addr=%0d data=%h", i, gpr_wen, gpr_waddr, gpr_wdata, exp_a[i], exp_d[i]); end
    end
    req_valid = '0;
  endtask

  task automatic test_x0;
    req_valid = 3'b100;
    req_addr  = {5'd0, 5'd6, 5'd5};
    req_data  = {64'hFFFF, 64'hB, 64'hA};
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL x0_ready got=%b exp=100", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (gpr_wen !== 1'b0 || gpr_waddr !== 5'd0 || gpr_wdata !== 64'hFFFF) begin errors++;
      $display("FAIL x0_write got wen=%b addr=%0d data=%h exp wen=0 addr=0 data=ffff", gpr_wen, gpr_waddr, gpr_wdata); end
    tick();
    checks++; if (gpr_wen !== 1'b0 || gpr_wdata !== 64'hFFFF) begin errors++;
      $display("FAIL idle_hold got wen=%b data=%h exp wen=0 data=ffff", gpr_wen, gpr_wdata); end
  endtask

  task automatic test_hold;
    req_addr  = {5'd7, 5'd6, 5'd5};
    req_data  = {64'hC, 64'hB, 64'hA};
    req_valid = 3'b011;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL hold_ready i=%0d got=%b exp=000", i, req_ready); end
      tick();
      checks++; if (gpr_wen !== 1'b0) begin errors++; $display("FAIL hold_wen i=%0d got=%b exp=0", i, gpr_wen); end
    end
    hold = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL hold_release0 got=%b exp=001", req_ready); end
    tick();
    req_valid = 3'b010;
    checks++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd5) begin errors++;
      $display("FAIL hold_write0 got wen=%b addr=%0d exp wen=1 addr=5", gpr_wen, gpr_waddr); end
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL hold_release1 got=%b exp=010", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd6 || gpr_wdata !== 64'hB) begin errors++;
      $display("FAIL hold_write1 got wen=%b addr=%0d data=%h exp wen=1 addr=6 data=b", gpr_wen, gpr_waddr, gpr_wdata); end
  endtask

  task automatic test_reset_mid;
    req_valid = 3'b010;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL mid_ready got=%b exp=010", req_ready); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (gpr_wen !== 1'b0 || gpr_waddr !== 5'd0) begin errors++;
      $display("FAIL mid_reset got wen=%b addr=%0d exp wen=0 addr=0", gpr_wen, gpr_waddr); end
    rst = 1'b0;
    req_valid = '0;
`ifdef GPR_CLEAR_ON_RESET_EN
    #1;
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL mid_sweep_busy got=%b exp=1", clr_busy); end
    tick();
    checks++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd1) begin errors++;
      $display("FAIL mid_sweep_restart got wen=%b addr=%0d exp wen=1 addr=1", gpr_wen, gpr_waddr); end
    repeat (30) tick();
`endif
    req_valid = 3'b011;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL mid_last_restored got=%b exp=001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd5) begin errors++;
      $display("FAIL mid_after_write got wen=%b addr=%0d exp wen=1 addr=5", gpr_wen, gpr_waddr); end
  endtask

  initial begin
    test_reset();
`ifdef GPR_CLEAR_ON_RESET_EN
    test_clear();
`else
    test_first_grant();
`endif
    test_round_robin();
    test_x0();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
